// File: rtl/sar_pkg.sv
// Shared definitions for the successive-approximation search controller.
//   sar_state_t : controller FSM states
//   CMP_*       : comparator result codes, packed as {gth, eq, lth}
package sar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } sar_state_t;

  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

endpackage

// File: rtl/sar_cmp_decode.sv
// Comparator result decoder (purely combinational).
//   cmp_gth/cmp_eq/cmp_lth : raw comparator result bits
//   keep    : the trial bit under test stays set (GT or EQ)
//   stop    : the search ends at this step (EQ or illegal code)
//   illegal : code is not one of GT/EQ/LT
module sar_cmp_decode
  import sar_pkg::*;
(
  input  logic cmp_gth,
  input  logic cmp_eq,
  input  logic cmp_lth,
  output logic keep,
  output logic stop,
  output logic illegal
);

  logic [2:0] code;

  always_comb begin
    code    = {cmp_gth, cmp_eq, cmp_lth};
    keep    = 1'b0;
    stop    = 1'b0;
    illegal = 1'b0;
    case (code)
      CMP_GT: keep = 1'b1;
      CMP_EQ: begin
        keep = 1'b1;
        stop = 1'b1;
      end
      CMP_LT: keep = 1'b0;
      default: begin
        stop    = 1'b1;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: drives a trial operand to an
// external magnitude comparator and resolves the target MSB first.
//   clk, rst_n          : clock, synchronous active-low reset
//   start               : begin a search (sampled only in IDLE)
//   cmp_gth/eq/lth      : comparator result for the current trial
//   trial               : registered operand to the comparator
//   busy                : search in progress
//   done                : one-cycle completion pulse
//   result/exact/err/steps : outcome, valid from done until the next start
module sar_search_ctrl
  import sar_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CMP_LAT = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         cmp_gth,
  input  logic                         cmp_eq,
  input  logic                         cmp_lth,
  output logic [WIDTH-1:0]             trial,
  output logic                         busy,
  output logic                         done,
  output logic [WIDTH-1:0]             result,
  output logic                         exact,
  output logic                         err,
  output logic [$clog2(WIDTH+1)-1:0]   steps
);

  localparam int unsigned IDX_W  = $clog2(WIDTH);
  localparam int unsigned STEP_W = $clog2(WIDTH+1);
  localparam int unsigned CNT_W  = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;

  sar_state_t        state_q, state_d;
  logic [WIDTH-1:0]  trial_q, trial_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              exact_q, exact_d;
  logic              err_q, err_d;

  logic             keep, stop, illegal;
  logic             sample, finish;
  logic [WIDTH-1:0] bit_mask, applied;

  sar_cmp_decode u_dec (
    .cmp_gth (cmp_gth),
    .cmp_eq  (cmp_eq),
    .cmp_lth (cmp_lth),
    .keep    (keep),
    .stop    (stop),
    .illegal (illegal)
  );

  // Comparator is sampled at the edge ending the last settle cycle.
  assign sample   = (state_q == ST_SETTLE) && (cnt_q == CNT_W'(CMP_LAT - 1));
  assign finish   = sample && (stop || (idx_q == '0));
  assign bit_mask = WIDTH'(1) << idx_q;
  assign applied  = keep ? trial_q : (trial_q & ~bit_mask);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      trial_q  <= '0;
      result_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      steps_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      exact_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      steps_q  <= steps_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      exact_q  <= exact_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_SETTLE;
      ST_SETTLE: if (finish) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    trial_d  = trial_q;
    result_d = result_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    steps_d  = steps_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    exact_d  = exact_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          trial_d = WIDTH'(1) << (WIDTH - 1);
          idx_d   = IDX_W'(WIDTH - 1);
          cnt_d   = '0;
          steps_d = '0;
          exact_d = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (!sample) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          steps_d = steps_q + STEP_W'(1);
          if (finish) begin
            // trial keeps its last driven value; only result sees the decision
            result_d = applied;
            exact_d  = stop && !illegal;
            err_d    = illegal;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end else begin
            trial_d = applied | (bit_mask >> 1);
            idx_d   = idx_q - IDX_W'(1);
            cnt_d   = '0;
          end
        end
      end
      default: ;
    endcase
  end

  assign trial  = trial_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign exact  = exact_q;
  assign err    = err_q;
  assign steps  = steps_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Testbench for sar_search_ctrl: two instances (CMP_LAT=1 and CMP_LAT=3),
// each answered by a comparator model against a bench-held target, with an
// optional forced code on a chosen compare step.
module tb_sar_search_ctrl;
  import sar_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_n_v   [2];
  logic       start_v   [2];
  logic [7:0] trial_v   [2];
  logic       busy_v    [2];
  logic       done_v    [2];
  logic [7:0] result_v  [2];
  logic       exact_v   [2];
  logic       err_v     [2];
  logic [3:0] steps_v   [2];
  logic [7:0] target    [2];
  logic       force_on  [2];
  logic [2:0] force_code[2];
  logic [2:0] code_v    [2];

  function automatic logic [2:0] model_code(input logic [7:0] t, input logic [7:0] tr);
    if (t > tr) return CMP_GT;
    else if (t == tr) return CMP_EQ;
    else return CMP_LT;
  endfunction

  always_comb begin
    for (int i = 0; i < 2; i++)
      code_v[i] = force_on[i] ? force_code[i] : model_code(target[i], trial_v[i]);
  end

  sar_search_ctrl #(.WIDTH(8), .CMP_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n_v[0]), .start(start_v[0]),
    .cmp_gth(code_v[0][2]), .cmp_eq(code_v[0][1]), .cmp_lth(code_v[0][0]),
    .trial(trial_v[0]), .busy(busy_v[0]), .done(done_v[0]), .result(result_v[0]),
    .exact(exact_v[0]), .err(err_v[0]), .steps(steps_v[0])
  );

  sar_search_ctrl #(.WIDTH(8), .CMP_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n_v[1]), .start(start_v[1]),
    .cmp_gth(code_v[1][2]), .cmp_eq(code_v[1][1]), .cmp_lth(code_v[1][0]),
    .trial(trial_v[1]), .busy(busy_v[1]), .done(done_v[1]), .result(result_v[1]),
    .exact(exact_v[1]), .err(err_v[1]), .steps(steps_v[1])
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  typedef struct {
    string       name;
    int          sel;
    logic [7:0]  result;
    logic        exact;
    logic        err;
    logic [3:0]  steps;
    int unsigned rel;
    int unsigned drive_cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (done_v[i] === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done[%0d]: got done=1 expected no pulse", i);
        end else begin
          mon_e = sb_q.pop_front();
          check({mon_e.name, "/instance"}, i, mon_e.sel);
          check({mon_e.name, "/result"}, result_v[i], mon_e.result);
          check({mon_e.name, "/exact"}, exact_v[i], mon_e.exact);
          check({mon_e.name, "/err"}, err_v[i], mon_e.err);
          check({mon_e.name, "/steps"}, steps_v[i], mon_e.steps);
          check({mon_e.name, "/latency"}, cyc - mon_e.drive_cyc, mon_e.rel);
          check({mon_e.name, "/busy_at_done"}, busy_v[i], 0);
        end
      end
    end
  end

  logic [7:0] got_trials[$];

  // Drives one search; compare n occupies elapsed cycles (n-1)*lat+1 .. n*lat
  // after the start-sampling edge, which is where a forced code is applied.
  task automatic run_search(input int sel, input string name, input logic [7:0] tgt,
                            input int fstep, input logic [2:0] fcode,
                            input logic [7:0] e_res, input logic e_exact, input logic e_err,
                            input logic [3:0] e_steps, input int unsigned e_rel,
                            input bit hold_start);
    int unsigned lat;
    int          n;
    bit          seen;
    exp_t        e;
    lat  = (sel == 0) ? 1 : 3;
    seen = 1'b0;
    @(negedge clk);
    target[sel]     = tgt;
    force_on[sel]   = 1'b0;
    force_code[sel] = fcode;
    start_v[sel]    = 1'b1;
    e.name = name; e.sel = sel; e.result = e_res; e.exact = e_exact; e.err = e_err;
    e.steps = e_steps; e.rel = e_rel; e.drive_cyc = cyc;
    sb_q.push_back(e);
    got_trials.delete();
    for (int el = 1; el <= 200 && !seen; el++) begin
      @(negedge clk);
      if (done_v[sel] === 1'b1) begin
        seen = 1'b1;
        force_on[sel] = 1'b0;
      end else begin
        if (!hold_start) start_v[sel] = 1'b0;
        n = (el - 1) / lat + 1;
        force_on[sel] = (n == fstep);
        if ((el - 1) % lat == 0) got_trials.push_back(trial_v[sel]);
        else check({name, "/trial_hold"}, trial_v[sel], got_trials[$]);
      end
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s/timeout: got no done expected done within 200 cycles", name);
      sb_q.delete();
    end
    // start may still be high here; the DONE->IDLE edge must ignore it
    @(negedge clk);
    check({name, "/done_width"}, done_v[sel], 0);
    start_v[sel] = 1'b0;
    @(negedge clk);
    check({name, "/idle_after"}, busy_v[sel], 0);
  endtask

  typedef struct {
    string       name;
    int          sel;
    logic [7:0]  tgt;
    int          fstep;
    logic [2:0]  fcode;
    logic [7:0]  res;
    logic        exact;
    logic        err;
    logic [3:0]  steps;
    int unsigned rel;
  } vec_t;

  vec_t       vecs[10];
  logic [7:0] seq_a5[8];

  task automatic check_a5_seq(input string name);
    logic [7:0] g;
    check({name, "/trial_count"}, got_trials.size(), 8);
    for (int i = 0; i < 8; i++) begin
      g = (i < got_trials.size()) ? got_trials[i] : 8'hxx;
      check($sformatf("%s/trial_seq[%0d]", name, i), g, seq_a5[i]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"a5",     0, 8'hA5, 0, 3'b000, 8'hA5, 1'b1, 1'b0, 4'd8, 9};
    vecs[1] = '{"x80",    0, 8'h80, 0, 3'b000, 8'h80, 1'b1, 1'b0, 4'd1, 2};
    vecs[2] = '{"zero",   0, 8'h00, 0, 3'b000, 8'h00, 1'b0, 1'b0, 4'd8, 9};
    vecs[3] = '{"err110", 0, 8'hA5, 3, 3'b110, 8'h80, 1'b0, 1'b1, 4'd3, 4};
    vecs[4] = '{"x40",    0, 8'h40, 0, 3'b000, 8'h40, 1'b1, 1'b0, 4'd2, 3};
    vecs[5] = '{"x01",    0, 8'h01, 0, 3'b000, 8'h01, 1'b1, 1'b0, 4'd8, 9};
    vecs[6] = '{"x7f",    0, 8'h7F, 0, 3'b000, 8'h7F, 1'b1, 1'b0, 4'd8, 9};
    vecs[7] = '{"err000", 0, 8'hA5, 1, 3'b000, 8'h00, 1'b0, 1'b1, 4'd1, 2};
    vecs[8] = '{"err111", 0, 8'hA5, 8, 3'b111, 8'hA4, 1'b0, 1'b1, 4'd8, 9};
    vecs[9] = '{"lat3ff", 1, 8'hFF, 0, 3'b000, 8'hFF, 1'b1, 1'b0, 4'd8, 25};
    seq_a5  = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};

    for (int i = 0; i < 2; i++) begin
      rst_n_v[i] = 1'b0; start_v[i] = 1'b0; target[i] = 8'h00;
      force_on[i] = 1'b0; force_code[i] = 3'b000;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset[%0d]/trial", i), trial_v[i], 0);
      check($sformatf("reset[%0d]/busy", i), busy_v[i], 0);
      check($sformatf("reset[%0d]/done", i), done_v[i], 0);
      check($sformatf("reset[%0d]/result", i), result_v[i], 0);
      check($sformatf("reset[%0d]/flags", i), {exact_v[i], err_v[i], steps_v[i]}, 0);
    end
    rst_n_v[0] = 1'b1;
    rst_n_v[1] = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_start/busy", busy_v[0], 0);

    for (int i = 0; i < 10; i++) begin
      run_search(vecs[i].sel, vecs[i].name, vecs[i].tgt, vecs[i].fstep, vecs[i].fcode,
                 vecs[i].res, vecs[i].exact, vecs[i].err, vecs[i].steps, vecs[i].rel, 1'b0);
      if (i == 0) begin
        check_a5_seq("a5");
        check("a5/trial_held", trial_v[0], 8'hA5);
      end
    end

    // Reset during the 4th compare abandons the search without a done pulse.
    @(negedge clk);
    target[0]   = 8'hA5;
    force_on[0] = 1'b0;
    start_v[0]  = 1'b1;
    for (int el = 1; el <= 4; el++) begin
      @(negedge clk);
      start_v[0] = 1'b0;
    end
    check("rst_mid/trial_before", trial_v[0], 8'hB0);
    rst_n_v[0] = 1'b0;
    @(negedge clk);
    check("rst_mid/busy", busy_v[0], 0);
    check("rst_mid/trial", trial_v[0], 0);
    check("rst_mid/done", done_v[0], 0);
    check("rst_mid/result", result_v[0], 0);
    rst_n_v[0] = 1'b1;
    repeat (12) @(negedge clk);
    check("rst_mid/still_idle", busy_v[0], 0);

    // Fresh run with start held high throughout busy and into DONE.
    run_search(0, "a5_hold", 8'hA5, 0, 3'b000, 8'hA5, 1'b1, 1'b0, 4'd8, 9, 1'b1);
    check_a5_seq("a5_hold");

    repeat (3) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
